div_iter_unit: RTL and testbench

Iterative 32-bit radix-2 divider that answers the divide requests of the execute pipeline stage. It latches operands when the stage holds a valid divide, drives the stage's stall input until the result is ready, and presents a 64-bit `{remainder, quotient}` result that the stage captures as its div result. It sits beside the execute stage register and closes the stall side of the valid/allowin handshake.

---
 rtl/div_iter_unit.sv | 115 +++++++++++
 tb/tb_div_iter_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/div_iter_unit.sv
// Iterative 32-bit radix-2 restoring divider for the execute stage; result is {remainder, quotient}.
// Optional build macro DIV_ZERO_EARLY_EN: a zero divisor completes in one cycle instead of 32 steps.
module div_iter_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_req,
    input  logic        div_sign,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        post_allowin,
    input  logic        div_cancel,
    output logic        div_stall,
    output logic        div_done,
    output logic [63:0] div_res
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvsr;
    logic        r_q_neg;
    logic        r_r_neg;
    logic [63:0] r_res;

    logic        w_dvd_neg;
    logic        w_dvs_neg;
    logic        w_dvs_zero;
    logic [31:0] w_dvd_mag;
    logic [31:0] w_dvs_mag;
    logic [32:0] w_rem_sh;
    logic [32:0] w_trial;
    logic        w_ge;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quo_nx;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_dvd_neg  = div_sign & dividend[31];
    assign w_dvs_neg  = div_sign & divisor[31];
    assign w_dvs_zero = (divisor == 32'd0);
    assign w_dvd_mag  = w_dvd_neg ? (32'd0 - dividend) : dividend;
    assign w_dvs_mag  = w_dvs_neg ? (32'd0 - divisor) : divisor;

    // One restoring step: shift {rem, quo} left, keep the trial difference if it did not go negative.
    assign w_rem_sh  = {r_rem, r_quo[31]};
    assign w_trial   = w_rem_sh - {1'b0, r_dvsr};
    assign w_ge      = (w_rem_sh >= {1'b0, r_dvsr});
    assign w_rem_nx  = w_ge ? w_trial[31:0] : w_rem_sh[31:0];
    assign w_quo_nx  = {r_quo[30:0], w_ge};
    assign w_quo_fix = r_q_neg ? (32'd0 - w_quo_nx) : w_quo_nx;
    assign w_rem_fix = r_r_neg ? (32'd0 - w_rem_nx) : w_rem_nx;

    assign div_stall = (((r_state == S_IDLE) & div_req) | (r_state == S_BUSY)) & ~div_cancel;
    assign div_done  = (r_state == S_DONE);
    assign div_res   = r_res;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_res   <= 64'd0;
            // NOTE: the working registers need no reset; they are always loaded on acceptance before use.
        end else if (div_cancel) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (div_req) begin
                        r_cnt  <= 5'd0;
                        r_rem  <= 32'd0;
                        r_dvsr <= w_dvs_mag;
                        // A zero divisor runs on the raw dividend with no sign fix: the steps then
                        // naturally leave remainder = dividend and quotient = all ones.
                        r_quo   <= w_dvs_zero ? dividend : w_dvd_mag;
                        r_q_neg <= ~w_dvs_zero & (w_dvd_neg ^ w_dvs_neg);
                        r_r_neg <= ~w_dvs_zero & w_dvd_neg;
`ifdef DIV_ZERO_EARLY_EN
                        if (w_dvs_zero) begin
                            r_res   <= {dividend, 32'hFFFF_FFFF};
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_BUSY;
                        end
`else
                        r_state <= S_BUSY;
`endif
                    end
                end
                S_BUSY: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_res   <= {w_rem_fix, w_quo_fix};
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (post_allowin) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_unit.sv
// Scoreboard bench for div_iter_unit: directed divides push expected results, a monitor checks on div_done.
module tb_div_iter_unit;

    logic        clk;
    logic        reset;
    logic        div_req;
    logic        div_sign;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        post_allowin;
    logic        div_cancel;
    logic        div_stall;
    logic        div_done;
    logic [63:0] div_res;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic prev_done = 1'b0;

`ifdef DIV_ZERO_EARLY_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    div_iter_unit dut (
        .clk          (clk),
        .reset        (reset),
        .div_req      (div_req),
        .div_sign     (div_sign),
        .dividend     (dividend),
        .divisor      (divisor),
        .post_allowin (post_allowin),
        .div_cancel   (div_cancel),
        .div_stall    (div_stall),
        .div_done     (div_done),
        .div_res      (div_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare on the first DONE cycle of each result.
    always @(negedge clk) begin
        if (!reset && div_done && !prev_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("div_res", div_res, e.res);
                check("latency", 64'(cyc - e.acc), 64'(e.lat));
            end
        end
        prev_done = div_done;
    end

    // Called just after a posedge; leaves the unit IDLE just after a posedge with div_req low.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input int hold);
        exp_t e;
        int   stalls;
        int   n;
        div_req      = 1'b1;
        div_sign     = sgn;
        dividend     = a;
        divisor      = b;
        post_allowin = (hold == 0);
        e.res = exp;
        e.lat = lat;
        e.acc = cyc;
        sb.push_back(e);
        stalls = 0;
        n      = 0;
        forever begin
            @(negedge clk);
            if (div_stall) stalls++;
            if (div_done) break;
            if (n == 1) begin
                dividend = ~a;
                divisor  = ~b;
            end
            n++;
            if (n > 100) begin
                check("done_timeout", 64'd0, 64'd1);
                break;
            end
        end
        check("stall_cycles", 64'(stalls), 64'(lat));
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                check("hold_res", div_res, exp);
                check("hold_done", 64'(div_done), 64'd1);
                check("hold_stall", 64'(div_stall), 64'd0);
            end
            @(posedge clk); #1;
            post_allowin = 1'b1;
        end
        @(posedge clk); #1;
        div_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        div_req      = 1'b0;
        div_sign     = 1'b0;
        dividend     = 32'd0;
        divisor      = 32'd0;
        post_allowin = 1'b1;
        div_cancel   = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_done", 64'(div_done), 64'd0);
        check("rst_res", div_res, 64'd0);
        check("rst_stall", 64'(div_stall), 64'd0);
        @(posedge clk); #1;

        do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 0);
        do_div(1'b0, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, ZLAT, 0);
        do_div(1'b1, 32'h8000_0001, 32'd0, {32'h8000_0001, 32'hFFFF_FFFF}, ZLAT, 0);
        do_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, 33, 0);
        do_div(1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 33, 0);
        do_div(1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 33, 5);
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33, 0);

        // Cancel partway through BUSY; nothing is expected from this request.
        div_req  = 1'b1;
        div_sign = 1'b0;
        dividend = 32'd100;
        divisor  = 32'd7;
        repeat (11) @(posedge clk);
        #1 div_cancel = 1'b1;
        @(negedge clk);
        check("cancel_stall", 64'(div_stall), 64'd0);
        @(posedge clk); #1;
        div_cancel = 1'b0;
        do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0);

        // Reset in the middle of BUSY.
        div_req  = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        repeat (16) @(posedge clk);
        #1;
        reset   = 1'b1;
        div_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_res", div_res, 64'd0);
        check("midrst_done", 64'(div_done), 64'd0);
        check("midrst_stall", 64'(div_stall), 64'd0);

        repeat (40) @(negedge clk);
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
